rle_rx: RTL and testbench
=========================

RLE_RX -- requirements
Module: rle_rx

Interface
REQ-001 The block SHALL have no parameters; all frame constants are fixed.
REQ-002 Port clock  in  1  single system clock; all state SHALL update on its rising edge.
REQ-003 Port reset_  in  1  reset, asynchronous, active-low.
REQ-004 Port rxd  in  1  serial line, synchronous to clock, one bit per clock, idle = mark (1).
REQ-005 Port rfd  in  1  consumer ready-for-data, active-low.
REQ-006 Port dav_  out  1  data-available to consumer, active-low.
REQ-007 Port colore  out  1  colour bit of the last accepted frame.
REQ-008 Port count  out  7  run-length field N of the last accepted frame.
REQ-009 Port endline  out  1  1 when the last accepted frame was the end-of-line code.
REQ-010 Port ferr  out  1  one-clock pulse on framing error.
REQ-011 Port ovr  out  1  one-clock pulse on overrun (frame lost).

Function
REQ-012 Frame SHALL be 10 bits, one per clock: start 0, data d0..d7 LSB first, stop 1; data byte = {N[6:0], B}.
REQ-013 Receive FSM states SHALL be HUNT, DATA, STOP, BREAK.
REQ-014 HUNT: edge E0 sampling rxd=0 -> DATA, bit counter = 0; rxd=1 -> stay.
REQ-015 DATA: edges E1..E8 SHALL shift rxd into an 8-bit register LSB first; after E8 -> STOP.
REQ-016 STOP at E9: rxd=1 -> frame valid, HUNT; rxd=0 -> ferr=1 for one clock, frame discarded, BREAK.
REQ-017 BREAK SHALL stay until rxd=1 is sampled, then -> HUNT; no start detected while in BREAK.
REQ-018 A start bit SHALL be accepted at E10, immediately after a valid stop (no idle bit required).
REQ-019 Valid frame, byte = 8'h00: endline=1, colore=0, count=0; otherwise endline=0, colore=d0, count=d7..d1.
REQ-020 Output handshake FSM states SHALL be OIDLE (dav_=1), OWAIT (dav_=0, until rfd=0), ORELEASE (dav_=1, until rfd=1) -> OIDLE.
REQ-021 Valid frame at E9 with output FSM in OIDLE: colore/count/endline load and dav_=0 after E9 (latency 0 clocks after stop sample).
REQ-022 Valid frame at E9 with output FSM not in OIDLE: frame dropped, outputs unchanged, ovr=1 for one clock after E9.
REQ-023 colore/count/endline SHALL stay stable from dav_ falling until the output FSM returns to OIDLE.
REQ-024 Receive FSM SHALL never stall on the consumer; reception continues during any handshake state.
REQ-025 ferr and ovr SHALL never be asserted in the same clock (a frame is either invalid or dropped).

Reset
REQ-026 While reset_=0: receive FSM=HUNT, output FSM=OIDLE, dav_=1, colore=0, count=0, endline=0, ferr=0, ovr=0, shift register and bit counter cleared.
REQ-027 Reset mid-frame or mid-handshake SHALL discard the partial frame/pending data; after release, hunting restarts at the first edge.

Structure
REQ-028 Shared package rle_pkg SHALL hold mark=1, spacing=0, start_bit=0, end_bit=1, ENDLINE_CODE=8'h00, FRAME_BITS=10, and both FSM state encodings; the existing transmitter reuses them.
REQ-029 One sub-module rle_rx_hs SHALL implement the output handshake FSM and output registers (inputs: load, colore/count/endline; outputs: dav_, busy).
REQ-030 Top SHALL be split into datapath (shift register, counter, decode) and control (receive FSM) as in the team's other serial blocks.

Verification
REQ-031 Frame 0,1,1,0,1,0,0,0,0,1 (byte 0x0B), rfd=1 -> after E9 dav_=0, colore=1, count=5, endline=0; rfd=0 -> dav_=1; rfd=1 -> OIDLE.
REQ-032 Frame byte 0x00 with valid stop -> endline=1, colore=0, count=0, dav_=0.
REQ-033 Frame 0x0B with stop=0, rxd held 0 for 5 further clocks, then 1 -> ferr pulse after E9, dav_ stays 1, no start detected until rxd=1 sampled.
REQ-034 rfd held 1, frames 0x0B then 0x15 back-to-back -> first presented (count=5), second dropped, ovr pulse after its E9, outputs still count=5.
REQ-035 reset_=0 during d4 of a frame, released, then frame 0x03 -> all outputs at reset values, then colore=1, count=1, dav_=0.
REQ-036 Two valid frames with stop/start adjacent (E9 then E10) and consumer answering within 3 clocks -> both delivered in order, no ferr/ovr.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared RLE line constants and state encodings. The transmitter uses the same
// frame constants, so the receiver must not redefine any of them locally.
package rle_pkg;

    localparam logic MARK      = 1'b1;
    localparam logic SPACING   = 1'b0;
    localparam logic START_BIT = 1'b0;
    localparam logic END_BIT   = 1'b1;

    localparam logic [7:0] ENDLINE_CODE = 8'h00;
    localparam int         FRAME_BITS   = 10;

    // receive FSM
    localparam logic [1:0] HUNT  = 2'd0;
    localparam logic [1:0] DATA  = 2'd1;
    localparam logic [1:0] STOP  = 2'd2;
    localparam logic [1:0] BREAK = 2'd3;

    // output handshake FSM
    localparam logic [1:0] OIDLE    = 2'd0;
    localparam logic [1:0] OWAIT    = 2'd1;
    localparam logic [1:0] ORELEASE = 2'd2;

    typedef struct packed {
        logic       colore;
        logic [6:0] count;
        logic       endline;
    } rle_sym_t;

    // The all-zero byte is the end-of-line code; every other byte is {N, colour}.
    function automatic rle_sym_t rle_decode(input logic [7:0] b);
        rle_sym_t s;
        if (b == ENDLINE_CODE) begin
            s.colore  = 1'b0;
            s.count   = '0;
            s.endline = 1'b1;
        end else begin
            s.colore  = b[0];
            s.count   = b[7:1];
            s.endline = 1'b0;
        end
        return s;
    endfunction

endpackage

// File: rtl/rle_rx_hs.sv
// Consumer handshake for rle_rx: holds the last delivered symbol and drives the
// active-low dav_/rfd four-phase exchange.
module rle_rx_hs
    import rle_pkg::*;
(
    input  logic       clock,
    input  logic       reset_,
    input  logic       load,
    input  logic       new_colore,
    input  logic [6:0] new_count,
    input  logic       new_endline,
    input  logic       rfd,
    output logic       dav_,
    output logic       busy,
    output logic       colore,
    output logic [6:0] count,
    output logic       endline
);

    logic [1:0] state;

    // Output registers only move on a load in OIDLE, which keeps them stable
    // across the whole handshake.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state   <= OIDLE;
            colore  <= 1'b0;
            count   <= '0;
            endline <= 1'b0;
        end else begin
            case (state)
                OIDLE: begin
                    if (load) begin
                        state   <= OWAIT;
                        colore  <= new_colore;
                        count   <= new_count;
                        endline <= new_endline;
                    end
                end
                OWAIT:    if (!rfd) state <= ORELEASE;
                ORELEASE: if (rfd)  state <= OIDLE;
                default:            state <= OIDLE;
            endcase
        end
    end

    assign dav_ = (state != OWAIT);
    assign busy = (state != OIDLE);

endmodule

// File: rtl/rle_rx.sv
// RLE serial receiver: 10-bit frames (start, 8 data LSB first, stop) decoded into
// colour/run-length symbols and offered to a consumer over a dav_/rfd handshake.
module rle_rx
    import rle_pkg::*;
(
    input  logic       clock,
    input  logic       reset_,
    input  logic       rxd,
    input  logic       rfd,
    output logic       dav_,
    output logic       colore,
    output logic [6:0] count,
    output logic       endline,
    output logic       ferr,
    output logic       ovr
);

    localparam logic [2:0] LAST_DATA = 3'(FRAME_BITS - 3);

    logic [1:0] rx_state;
    logic [7:0] shreg;
    logic [2:0] bitcnt;
    logic       frame_ok;
    logic       frame_bad;
    logic       hs_busy;
    rle_sym_t   sym;

    // ---------------- control: receive FSM ----------------
    assign frame_ok  = (rx_state == STOP) && (rxd == END_BIT);
    assign frame_bad = (rx_state == STOP) && (rxd == SPACING);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            rx_state <= HUNT;
        end else begin
            case (rx_state)
                HUNT:  if (rxd == START_BIT)     rx_state <= DATA;
                DATA:  if (bitcnt == LAST_DATA)  rx_state <= STOP;
                STOP:  rx_state <= frame_ok ? HUNT : BREAK;
                BREAK: if (rxd == MARK)          rx_state <= HUNT;
                default:                         rx_state <= HUNT;
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (rx_state == HUNT) begin
            bitcnt <= '0;
        end else if (rx_state == DATA) begin
            shreg  <= {rxd, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
        end
    end

    assign sym = rle_decode(shreg);

    // A frame is either bad (ferr) or good-but-dropped (ovr), never both.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            ferr <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            ferr <= frame_bad;
            ovr  <= frame_ok && hs_busy;
        end
    end

    rle_rx_hs u_hs (
        .clock       (clock),
        .reset_      (reset_),
        .load        (frame_ok),
        .new_colore  (sym.colore),
        .new_count   (sym.count),
        .new_endline (sym.endline),
        .rfd         (rfd),
        .dav_        (dav_),
        .busy        (hs_busy),
        .colore      (colore),
        .count       (count),
        .endline     (endline)
    );

endmodule

// File: tb/tb_rle_rx.sv
// Directed bench for rle_rx: expected symbols are queued as frames are sent and
// compared whenever dav_ falls; pulse counts are totalled at the end.
module tb_rle_rx;

    logic       clock  = 1'b0;
    logic       reset_ = 1'b0;
    logic       rxd    = 1'b1;
    logic       rfd    = 1'b1;
    logic       dav_, colore, endline, ferr, ovr;
    logic [6:0] count;

    int n_assert = 0;
    int n_fail   = 0;
    int ferr_seen = 0, ovr_seen = 0, both_seen = 0;

    logic [8:0] sb[$];
    logic [8:0] exp_sym;
    logic       prev_dav = 1'b1;

    rle_rx dut (
        .clock   (clock),
        .reset_  (reset_),
        .rxd     (rxd),
        .rfd     (rfd),
        .dav_    (dav_),
        .colore  (colore),
        .count   (count),
        .endline (endline),
        .ferr    (ferr),
        .ovr     (ovr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // ack=1: consumer acknowledges the pending symbol during bits 1..2 of this frame
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit ack);
        for (int i = 0; i < 10; i++) begin
            rxd = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
            if (ack) rfd = (i == 1) ? 1'b0 : 1'b1;
            tick();
        end
        rxd = 1'b1;
    endtask

    task automatic handshake();
        rfd = 1'b0;
        tick();
        chk("dav_after_rfd_low", 32'(dav_), 1);
        rfd = 1'b1;
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dav"},     32'(dav_),    1);
        chk({tag, "_colore"},  32'(colore),  0);
        chk({tag, "_count"},   32'(count),   0);
        chk({tag, "_endline"}, 32'(endline), 0);
        chk({tag, "_ferr"},    32'(ferr),    0);
        chk({tag, "_ovr"},     32'(ovr),     0);
    endtask

    // Scoreboard: each falling dav_ must deliver the oldest queued symbol.
    always @(negedge clock) begin
        if (reset_) begin
            if (ferr) ferr_seen++;
            if (ovr) ovr_seen++;
            if (ferr && ovr) both_seen++;
            if (prev_dav && !dav_) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_sym = sb.pop_front();
                    chk("sb_symbol", 32'({colore, count, endline}), 32'(exp_sym));
                end
            end
        end
        prev_dav = dav_;
    end

    initial begin
        // reset
        tick();
        tick();
        chk_reset_vals("reset");
        reset_ = 1'b1;
        tick();

        // 0x0B: colour 1, N=5
        sb.push_back({1'b1, 7'd5, 1'b0});
        send_frame(8'h0B, 1'b1, 1'b0);
        chk("f0b_dav", 32'(dav_), 0);
        chk("f0b_colore", 32'(colore), 1);
        chk("f0b_count", 32'(count), 5);
        chk("f0b_endline", 32'(endline), 0);
        handshake();
        chk("f0b_hold_count", 32'(count), 5);

        // end-of-line code
        sb.push_back({1'b0, 7'd0, 1'b1});
        send_frame(8'h00, 1'b1, 1'b0);
        chk("eol_dav", 32'(dav_), 0);
        chk("eol_endline", 32'(endline), 1);
        chk("eol_colore", 32'(colore), 0);
        chk("eol_count", 32'(count), 0);
        handshake();

        // framing error, line held low, then recovery
        send_frame(8'h0B, 1'b0, 1'b0);
        chk("ferr_pulse", 32'(ferr), 1);
        chk("ferr_dav", 32'(dav_), 1);
        for (int i = 0; i < 5; i++) begin
            rxd = 1'b0;
            tick();
            if (i == 0) chk("ferr_one_clock", 32'(ferr), 0);
        end
        rxd = 1'b1;
        tick();
        tick();
        chk("break_no_dav", 32'(dav_), 1);
        sb.push_back({1'b1, 7'd10, 1'b0});
        send_frame(8'h15, 1'b1, 1'b0);
        chk("after_break_dav", 32'(dav_), 0);
        chk("after_break_count", 32'(count), 10);
        handshake();

        // overrun: consumer never answers between two back-to-back frames
        sb.push_back({1'b1, 7'd5, 1'b0});
        send_frame(8'h0B, 1'b1, 1'b0);
        chk("ovr_first_dav", 32'(dav_), 0);
        send_frame(8'h15, 1'b1, 1'b0);
        chk("ovr_pulse", 32'(ovr), 1);
        chk("ovr_ferr", 32'(ferr), 0);
        chk("ovr_count_kept", 32'(count), 5);
        chk("ovr_dav_kept", 32'(dav_), 0);
        tick();
        chk("ovr_one_clock", 32'(ovr), 0);
        handshake();

        // reset during d4, then a clean frame
        for (int i = 0; i < 5; i++) begin
            rxd = (i == 0) ? 1'b0 : ((8'h0B >> (i - 1)) & 8'h01) != 0;
            tick();
        end
        rxd = 1'b1;
        reset_ = 1'b0;
        #1;
        chk_reset_vals("midframe_reset");
        tick();
        reset_ = 1'b1;
        tick();
        tick();
        sb.push_back({1'b1, 7'd1, 1'b0});
        send_frame(8'h03, 1'b1, 1'b0);
        chk("f03_dav", 32'(dav_), 0);
        chk("f03_colore", 32'(colore), 1);
        chk("f03_count", 32'(count), 1);
        handshake();

        // adjacent frames with a prompt consumer
        sb.push_back({1'b1, 7'd42, 1'b0});
        sb.push_back({1'b0, 7'd64, 1'b0});
        send_frame(8'h55, 1'b1, 1'b0);
        chk("adj1_count", 32'(count), 42);
        send_frame(8'h80, 1'b1, 1'b1);
        chk("adj2_dav", 32'(dav_), 0);
        chk("adj2_colore", 32'(colore), 0);
        chk("adj2_count", 32'(count), 64);
        handshake();
        tick();

        chk("ferr_total", 32'(ferr_seen), 1);
        chk("ovr_total", 32'(ovr_seen), 1);
        chk("ferr_ovr_overlap", 32'(both_seen), 0);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
